// File: rtl/pixel_write_port_pkg.sv
// +----------------------------------------------------------------------+
// | pixel_write_port_pkg : framebuffer geometry, widths and port states   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package pixel_write_port_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int FB_WORDS = SCREEN_W * SCREEN_H;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOR_W  = 12;
  localparam int ADDR_W   = 17;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_CLEAR_WAIT = 2'd1,
    ST_CLEAR      = 2'd2,
    ST_CLEAR_END  = 2'd3
  } pwp_state_e;

  // Row-major linear word address; width is the row pitch in pixels.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y,
                                                input int width);
    return ADDR_W'(y) * ADDR_W'(width) + ADDR_W'(x);
  endfunction
endpackage

`default_nettype wire

// File: rtl/pixel_write_port_fifo.sv
// +----------------------------------------------------------------------+
// | pixel_fifo : synchronous FIFO of {addr, color} pixel write entries    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 29
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != DEPTH_CNT);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

`default_nettype wire

// File: rtl/pixel_write_port.sv
// +----------------------------------------------------------------------+
// | pixel_write_port : clips, addresses and buffers drawn pixels into     |
// | framebuffer writes; also performs full-screen clear. Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module pixel_write_port #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = pixel_write_port_pkg::SCREEN_W,
  parameter int SCREEN_H   = pixel_write_port_pkg::SCREEN_H
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  inX,
  input  logic [7:0]  inY,
  input  logic [11:0] inColor,
  input  logic        inWriteEn,
  output logic        inReady,
  input  logic        clearReq,
  input  logic [11:0] clearColor,
  output logic        clearDone,
  output logic [16:0] memAddr,
  output logic [11:0] memData,
  output logic        memWe,
  input  logic        memGrant,
  output logic [15:0] clipCount
);
  import pixel_write_port_pkg::*;

  localparam int ENTRY_W = ADDR_W + COLOR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  pwp_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic [15:0]        clip_count_q, clip_count_d;

  logic               accept, on_screen, fifo_push, fifo_pop, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({fb_addr(inX, inY, SCREEN_W), inColor}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Ready depends only on registered state and FIFO occupancy.
  assign inReady   = !reset && (state_q == ST_RUN) && (fifo_count != DEPTH_CNT);
  assign clearDone = (state_q == ST_CLEAR_END);
  assign clipCount = clip_count_q;

  always_comb begin
    memWe   = 1'b0;
    memAddr = fifo_head[ENTRY_W-1:COLOR_W];
    memData = fifo_head[COLOR_W-1:0];
    case (state_q)
      ST_CLEAR: begin
        memWe   = 1'b1;
        memAddr = clr_addr_q;
        memData = clr_color_q;
      end
      ST_CLEAR_END: memWe = 1'b0;
      default:      memWe = !fifo_empty;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_color_d  = clr_color_q;
    clip_count_d = clip_count_q;
    accept       = inWriteEn && inReady;
    on_screen    = (inX < X_W'(SCREEN_W)) && (inY < Y_W'(SCREEN_H));
    fifo_push    = accept && on_screen;
    fifo_pop     = ((state_q == ST_RUN) || (state_q == ST_CLEAR_WAIT)) && !fifo_empty && memGrant;
    if (accept && !on_screen && (clip_count_q != 16'hFFFF))
      clip_count_d = clip_count_q + 16'd1;

    case (state_q)
      ST_RUN:
        if (clearReq) state_d = ST_CLEAR_WAIT;
      ST_CLEAR_WAIT:
        if (fifo_empty) begin
          state_d     = ST_CLEAR;
          clr_color_d = clearColor;
          clr_addr_d  = '0;
        end
      ST_CLEAR:
        if (memGrant) begin
          if (clr_addr_q == LAST_ADDR) state_d = ST_CLEAR_END;
          else                         clr_addr_d = clr_addr_q + 1'b1;
        end
      ST_CLEAR_END:
        state_d = ST_RUN;
      default:
        state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      clr_addr_q   <= '0;
      clr_color_q  <= '0;
      clip_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_color_q  <= clr_color_d;
      clip_count_q <= clip_count_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_pixel_write_port.sv
// +----------------------------------------------------------------------+
// | tb_pixel_write_port : scoreboard bench for pixel_write_port           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_pixel_write_port;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  inX = '0;
  logic [7:0]  inY = '0;
  logic [11:0] inColor = '0;
  logic        inWriteEn = 1'b0;
  logic        inReady;
  logic        clearReq = 1'b0;
  logic [11:0] clearColor = '0;
  logic        clearDone;
  logic [16:0] memAddr;
  logic [11:0] memData;
  logic        memWe;
  logic        memGrant = 1'b1;
  logic [15:0] clipCount;

  pixel_write_port #(
    .FIFO_DEPTH (8),
    .SCREEN_W   (320),
    .SCREEN_H   (240)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .inX        (inX),
    .inY        (inY),
    .inColor    (inColor),
    .inWriteEn  (inWriteEn),
    .inReady    (inReady),
    .clearReq   (clearReq),
    .clearColor (clearColor),
    .clearDone  (clearDone),
    .memAddr    (memAddr),
    .memData    (memData),
    .memWe      (memWe),
    .memGrant   (memGrant),
    .clipCount  (clipCount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  done_expected = 0;
  int  done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int info);
    n_total++;
    $display("FAIL %s: got %0d, expected event", name, info);
  endtask

  // Monitor: every granted write must match the oldest expected entry.
  always @(negedge clock) begin : monitor
    wr_t e;
    if (!reset) begin
      if (memWe && memGrant) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_write", int'(memAddr));
        end else begin
          e = sb.pop_front();
          check("mem_write", {3'd0, memAddr, memData}, {3'd0, e.addr, e.data});
        end
      end
      if (clearDone) begin
        check("clear_done_ok", {30'd0, (done_expected > 0), (sb.size() == 0)}, 32'd3);
        done_seen++;
        if (done_expected > 0) done_expected--;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input logic [8:0] x, input logic [7:0] y, input logic [11:0] c,
                            input bit on, input logic [16:0] ea);
    int cyc;
    cyc = 0;
    inX = x; inY = y; inColor = c; inWriteEn = 1'b1;
    @(negedge clock);
    while (!inReady && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    if (!inReady) fail_now("accept_timeout", cyc);
    else if (on) sb.push_back('{ea, c});
    tick();
    inWriteEn = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int idx;
    int cyc;
    bit found;

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_inready", inReady, 0);
    check("rst_memwe", memWe, 0);
    check("rst_memaddr", memAddr, 0);
    check("rst_memdata", memData, 0);
    check("rst_clip", clipCount, 0);
    check("rst_cleardone", clearDone, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", inReady, 1);
    tick();

    // Single pixel, write one cycle after acceptance
    send_pixel(9'd160, 8'd45, 12'hBBB, 1'b1, 17'd14560);
    @(negedge clock);
    check("single_latency", {14'd0, memWe, memAddr}, {14'd0, 1'b1, 17'd14560});
    tick();
    drain();

    // Off-screen clipping and the far corner
    send_pixel(9'd320, 8'd0, 12'h111, 1'b0, 17'd0);
    send_pixel(9'd0, 8'd240, 12'h222, 1'b0, 17'd0);
    @(negedge clock);
    check("clip_count", clipCount, 2);
    check("clip_no_write", memWe, 0);
    tick();
    send_pixel(9'd319, 8'd239, 12'h5A5, 1'b1, 17'd76799);
    drain();

    // Back-pressure: 20 pixels with the memory stalled
    memGrant = 1'b0;
    idx = 0;
    for (int c = 0; c < 300 && idx < 20; c++) begin
      if (c == 12) begin
        check("bp_accepted", idx, 8);
        check("bp_ready_low", inReady, 0);
        memGrant = 1'b1;
      end
      inX = 9'(10 + idx); inY = 8'(3 + idx); inColor = 12'(idx * 37 + 5); inWriteEn = 1'b1;
      @(negedge clock);
      if (inReady) begin
        sb.push_back('{17'((3 + idx) * 320 + 10 + idx), 12'(idx * 37 + 5)});
        idx++;
      end
      tick();
    end
    inWriteEn = 1'b0;
    check("bp_total", idx, 20);
    drain();

    // Clear with 3 pixels buffered, random grant early on
    memGrant = 1'b0;
    send_pixel(9'd10, 8'd10, 12'h123, 1'b1, 17'd3210);
    send_pixel(9'd0, 8'd1, 12'h456, 1'b1, 17'd320);
    send_pixel(9'd5, 8'd200, 12'h789, 1'b1, 17'd64005);
    clearColor = 12'h000;
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 76800; i++) sb.push_back('{17'(i), 12'h000});
    done_expected = 1;
    @(negedge clock);
    check("clear_ready_low", inReady, 0);
    tick();
    cyc = 0;
    while (done_seen == 0 && cyc < 90000) begin
      memGrant = (cyc < 3000) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (done_seen == 0 && (cyc % 8192) == 100) check("clear_ready_low_run", inReady, 0);
      tick();
      cyc++;
    end
    check("clear_done_seen", done_seen, 1);
    check("clear_all_written", sb.size(), 0);
    @(negedge clock);
    check("ready_after_clear", inReady, 1);
    check("clip_persist", clipCount, 2);
    tick();

    // Reset in the middle of a clear
    memGrant = 1'b1;
    clearColor = 12'hF0F;
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int i = 0; i < 76800; i++) sb.push_back('{17'(i), 12'hF0F});
    done_expected = 1;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clock);
      if (memWe && memAddr == 17'd1000) found = 1'b1;
      tick();
    end
    check("reach_addr_1000", found, 1);
    reset = 1'b1;
    sb.delete();
    done_expected = 0;
    tick();
    @(negedge clock);
    check("midclr_rst_memwe", memWe, 0);
    check("midclr_rst_clip", clipCount, 0);
    check("midclr_rst_done", clearDone, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("midclr_ready", inReady, 1);
    repeat (20) tick();
    check("midclr_no_done", done_seen, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
